// File: rtl/spi_device.sv
// SPI target: byte-wide tx/rx with all SPI inputs resynchronised into clk_i.
// The SPI clock is oversampled, so clk_i must run at 8x SCK or faster.
module spi_device #(
  parameter logic CPOL = 1'b0,
  parameter logic CPHA = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       sck_i,
  input  logic       cs_ni,
  input  logic       sdi_i,
  output logic       sdo_o,
  output logic       sdo_en_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       tx_underrun_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o
);

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e      state;
  logic [1:0]  sck_sync, cs_sync, sdi_sync;
  logic        sck_d;
  logic [2:0]  bit_cnt;
  logic [7:0]  rx_sr, tx_sr;
  logic        first_shift;

  logic        sck_s, cs_s, sdi_s;
  logic        lead_edge, trail_edge, sample_edge, shift_edge, load_now;
  logic [7:0]  tx_load_val;

  assign sck_s = sck_sync[1];
  assign cs_s  = cs_sync[1];
  assign sdi_s = sdi_sync[1];

  assign lead_edge   = (sck_d == CPOL) && (sck_s != CPOL);
  assign trail_edge  = (sck_d != CPOL) && (sck_s == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge  : trail_edge;

  // In CPHA=0 the byte is loaded on selection, so the very first shift edge
  // must never reload even if a stray trailing edge arrives before any sample.
  assign load_now    = shift_edge && (bit_cnt == 3'd0) && !(!CPHA && first_shift);
  assign tx_load_val = tx_valid_i ? tx_data_i : 8'hFF;

  assign sdo_o = sdo_en_o ? tx_sr[7] : 1'b1;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sck_sync      <= {2{CPOL}};
      cs_sync       <= 2'b11;
      sdi_sync      <= 2'b11;
      sck_d         <= CPOL;
      state         <= IDLE;
      bit_cnt       <= 3'd0;
      rx_sr         <= 8'h00;
      tx_sr         <= 8'h00;
      first_shift   <= 1'b0;
      sdo_en_o      <= 1'b0;
      tx_ready_o    <= 1'b0;
      tx_underrun_o <= 1'b0;
      rx_data_o     <= 8'h00;
      rx_valid_o    <= 1'b0;
    end else begin
      sck_sync      <= {sck_sync[0], sck_i};
      cs_sync       <= {cs_sync[0], cs_ni};
      sdi_sync      <= {sdi_sync[0], sdi_i};
      sck_d         <= sck_s;
      tx_ready_o    <= 1'b0;
      tx_underrun_o <= 1'b0;
      rx_valid_o    <= 1'b0;

      case (state)
        IDLE: begin
          if (!cs_s) begin
            state       <= ACTIVE;
            sdo_en_o    <= 1'b1;
            bit_cnt     <= 3'd0;
            rx_sr       <= 8'h00;
            first_shift <= 1'b1;
            if (!CPHA) begin
              tx_sr         <= tx_load_val;
              tx_ready_o    <= tx_valid_i;
              tx_underrun_o <= !tx_valid_i;
            end
          end
        end
        ACTIVE: begin
          // Deselect wins over any edge seen in the same cycle; partial byte dropped.
          if (cs_s) begin
            state       <= IDLE;
            sdo_en_o    <= 1'b0;
            bit_cnt     <= 3'd0;
            rx_sr       <= 8'h00;
            tx_sr       <= 8'hFF;
            first_shift <= 1'b0;
          end else begin
            if (sample_edge) begin
              rx_sr   <= {rx_sr[6:0], sdi_s};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_data_o  <= {rx_sr[6:0], sdi_s};
                rx_valid_o <= 1'b1;
              end
            end
            if (shift_edge) begin
              first_shift <= 1'b0;
              if (load_now) begin
                tx_sr         <= tx_load_val;
                tx_ready_o    <= tx_valid_i;
                tx_underrun_o <= !tx_valid_i;
              end else begin
                tx_sr <= {tx_sr[6:0], 1'b1};
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_device.sv
// Bench for spi_device: a mode-0 and a mode-3 instance driven by a behavioural
// SPI host; a transaction-level model predicts MISO bytes, rx bytes and pulse counts.
module tb_spi_device;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      sck, cs, sdi;
  logic [1:0]      sdo, sdo_en, rdy, unr, rxv;
  logic [1:0][7:0] rxd;
  logic [7:0]      tx_data;
  logic            tx_valid;

  spi_device #(.CPOL(1'b0), .CPHA(1'b0)) u_m0 (
    .clk_i(clk), .rst_ni(rst_n), .sck_i(sck[0]), .cs_ni(cs[0]), .sdi_i(sdi[0]),
    .sdo_o(sdo[0]), .sdo_en_o(sdo_en[0]), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
    .tx_ready_o(rdy[0]), .tx_underrun_o(unr[0]), .rx_data_o(rxd[0]), .rx_valid_o(rxv[0]));

  spi_device #(.CPOL(1'b1), .CPHA(1'b1)) u_m3 (
    .clk_i(clk), .rst_ni(rst_n), .sck_i(sck[1]), .cs_ni(cs[1]), .sdi_i(sdi[1]),
    .sdo_o(sdo[1]), .sdo_en_o(sdo_en[1]), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
    .tx_ready_o(rdy[1]), .tx_underrun_o(unr[1]), .rx_data_o(rxd[1]), .rx_valid_o(rxv[1]));

  int cmp_cnt = 0;
  int err_cnt = 0;
  int exp_rdy[2], exp_unr[2], act_rdy[2], act_unr[2], act_rxv[2];
  logic [7:0] armed[2];
  logic [7:0] held[2];
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One load event: the byte the device must shift out and the pulse it must raise.
  task automatic arm(input int m, input logic [7:0] d, input logic v);
    tx_data  = d;
    tx_valid = v;
    armed[m] = v ? d : 8'hFF;
    if (v) exp_rdy[m]++;
    else   exp_unr[m]++;
  endtask

  task automatic select(input int m, input logic [7:0] d, input logic v);
    if (m == 0) arm(m, d, v);
    cs[m] = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic deselect(input int m);
    wait_clk(HALF);
    cs[m] = 1'b1;
    wait_clk(6);
    chk("sdo_en_after_deselect", sdo_en[m], 1'b0);
    chk("sdo_after_deselect", sdo[m], 1'b1);
    wait_clk(HALF);
  endtask

  // Host side of one byte (or nbits of it). Mode 0 loads the next byte on the
  // final falling edge; mode 3 loads on the first falling edge of this byte.
  task automatic xfer(input int m, input logic [7:0] host, input int nbits,
                      input logic [7:0] ld_d, input logic ld_v, output logic [7:0] miso);
    logic [7:0] exp_m;
    miso = 8'h00;
    if (m == 1) arm(m, ld_d, ld_v);
    exp_m = armed[m];
    if (nbits == 8) begin
      if (m == 0) q0.push_back(host);
      else        q1.push_back(host);
    end
    for (int i = 0; i < nbits; i++) begin
      if (m == 1) sck[1] = 1'b0;
      sdi[m] = host[7-i];
      wait_clk(HALF);
      sck[m] = 1'b1;
      miso = {miso[6:0], sdo[m]};
      if (m == 0 && nbits == 8 && i == 7) arm(0, ld_d, ld_v);
      wait_clk(HALF);
      if (m == 0) sck[0] = 1'b0;
    end
    chk("miso_bits", miso, exp_m >> (8 - nbits));
  endtask

  task automatic check_counts(input int m);
    chk("tx_ready_count", act_rdy[m], exp_rdy[m]);
    chk("tx_underrun_count", act_unr[m], exp_unr[m]);
    chk("rx_pending", (m == 0) ? q0.size() : q1.size(), 0);
  endtask

  // Per-cycle compare against the model: reset values, rx bytes in order, held data.
  initial begin : mon
    logic [7:0] e;
    logic have;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          chk("rst_rx_data", rxd[i], 8'h00);
          chk("rst_rx_valid", rxv[i], 1'b0);
          chk("rst_tx_ready", rdy[i], 1'b0);
          chk("rst_tx_underrun", unr[i], 1'b0);
          chk("rst_sdo_en", sdo_en[i], 1'b0);
          chk("rst_sdo", sdo[i], 1'b1);
          held[i] = 8'h00;
        end else begin
          if (rdy[i]) act_rdy[i]++;
          if (unr[i]) act_unr[i]++;
          if (rxv[i]) begin
            act_rxv[i]++;
            have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
            if (!have) chk("rx_valid_unexpected", rxv[i], 1'b0);
            else begin
              e = (i == 0) ? q0.pop_front() : q1.pop_front();
              chk("rx_byte", rxd[i], e);
              held[i] = e;
            end
          end else begin
            chk("rx_data_hold", rxd[i], held[i]);
          end
          if (!sdo_en[i]) chk("sdo_idle_high", sdo[i], 1'b1);
        end
      end
    end
  end

  initial begin : main
    logic [7:0] m;
    sck = 2'b10; cs = 2'b11; sdi = 2'b11;
    tx_data = 8'h00; tx_valid = 1'b0;
    rst_n = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 2; i++) begin
      chk("reset_rx_data", rxd[i], 8'h00);
      chk("reset_sdo_en", sdo_en[i], 1'b0);
    end
    rst_n = 1'b1;
    wait_clk(6);
    chk("post_reset_no_pulses", act_rdy[0] + act_unr[0] + act_rxv[0] + act_rdy[1] + act_unr[1] + act_rxv[1], 0);

    // mode 0: device sends A5, host sends 3C; trailing load finds no data
    select(0, 8'hA5, 1'b1);
    xfer(0, 8'h3C, 8, 8'h00, 1'b0, m);
    deselect(0);
    chk("m0_miso_A5", m, 8'hA5);
    chk("m0_rx_3C", rxd[0], 8'h3C);
    chk("m0_one_rx_valid", act_rxv[0], 1);
    chk("m0_one_tx_ready", act_rdy[0], 1);
    check_counts(0);

    // mode 3: two back-to-back bytes each way
    select(1, 8'h00, 1'b0);
    xfer(1, 8'h81, 8, 8'h81, 1'b1, m);
    chk("m3_miso_81", m, 8'h81);
    xfer(1, 8'h7E, 8, 8'h7E, 1'b1, m);
    chk("m3_miso_7E", m, 8'h7E);
    deselect(1);
    chk("m3_rx_last_7E", rxd[1], 8'h7E);
    chk("m3_two_rx_valid", act_rxv[1], 2);
    chk("m3_two_tx_ready", act_rdy[1], 2);
    check_counts(1);

    // underrun: nothing valid at load time
    select(0, 8'h12, 1'b0);
    xfer(0, 8'h5A, 8, 8'h00, 1'b0, m);
    deselect(0);
    chk("underrun_miso_FF", m, 8'hFF);
    chk("underrun_rx_5A", rxd[0], 8'h5A);
    chk("underrun_pulses", act_unr[0], 3);
    check_counts(0);

    // abort after 5 bits, then a clean byte
    select(0, 8'h12, 1'b1);
    xfer(0, 8'hF0, 5, 8'h00, 1'b0, m);
    deselect(0);
    chk("abort_rx_unchanged", rxd[0], 8'h5A);
    chk("abort_no_rx_valid", act_rxv[0], 2);
    select(0, 8'h96, 1'b1);
    xfer(0, 8'h55, 8, 8'h00, 1'b0, m);
    deselect(0);
    chk("after_abort_rx_55", rxd[0], 8'h55);
    chk("after_abort_miso_96", m, 8'h96);
    check_counts(0);

    // reset mid-byte, then a fresh transfer
    select(0, 8'h33, 1'b1);
    xfer(0, 8'hAA, 4, 8'h00, 1'b0, m);
    rst_n = 1'b0;
    wait_clk(3);
    chk("midrst_rx_data", rxd[0], 8'h00);
    chk("midrst_sdo", sdo[0], 1'b1);
    chk("midrst_sdo_en", sdo_en[0], 1'b0);
    cs[0] = 1'b1;
    sck[0] = 1'b0;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(6);
    select(0, 8'h3C, 1'b1);
    xfer(0, 8'hC3, 8, 8'h00, 1'b0, m);
    deselect(0);
    chk("after_rst_rx_C3", rxd[0], 8'hC3);
    chk("after_rst_miso_3C", m, 8'h3C);
    check_counts(0);
    check_counts(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/spi_device.md
SPI_DEVICE -- requirements
Module: spi_device

Interface
REQ-001 SHALL have parameter CPOL, default 0: SCK idle level.
REQ-002 SHALL have parameter CPHA, default 0: 0 = sample on leading edge and shift on trailing edge; 1 = shift on leading edge and sample on trailing edge.
REQ-003 SHALL have port clk_i, input, 1: single system clock; all logic is rising-edge clocked.
REQ-004 SHALL have port rst_ni, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port sck_i, input, 1: SPI clock from the host, asynchronous to clk_i.
REQ-006 SHALL have port cs_ni, input, 1: chip select, active-low, asynchronous.
REQ-007 SHALL have port sdi_i, input, 1: serial data from the host (MOSI).
REQ-008 SHALL have port sdo_o, output, 1: serial data to the host (MISO), MSB first.
REQ-009 SHALL have port sdo_en_o, output, 1: output enable for sdo_o, high while selected.
REQ-010 SHALL have port tx_data_i, input, 8: next byte to transmit.
REQ-011 SHALL have port tx_valid_i, input, 1: tx_data_i holds a valid byte.
REQ-012 SHALL have port tx_ready_o, output, 1: one-cycle pulse; tx_data_i consumed this cycle.
REQ-013 SHALL have port tx_underrun_o, output, 1: one-cycle pulse; a load occurred with tx_valid_i low.
REQ-014 SHALL have port rx_data_o, output, 8: last complete received byte.
REQ-015 SHALL have port rx_valid_o, output, 1: one-cycle pulse; rx_data_o updated.

Function
REQ-016 SHALL pass sck_i, cs_ni and sdi_i each through a 2-flop synchronizer; edge detection SHALL use one further registered copy of synced SCK.
REQ-017 SHALL define leading edge as the synced SCK leaving CPOL and trailing edge as the synced SCK returning to CPOL; sample edge and shift edge SHALL follow CPHA per REQ-002.
REQ-018 SHALL require clk_i frequency of at least 8x the SCK frequency; behaviour is undefined otherwise.
REQ-019 SHALL implement states IDLE and ACTIVE: IDLE->ACTIVE on synced cs_ni falling; ACTIVE->IDLE on synced cs_ni high.
REQ-020 SHALL ignore SCK edges in IDLE.
REQ-021 SHALL keep a 3-bit bit counter, cleared on entry to ACTIVE, incremented on each sample edge and wrapping 7->0.
REQ-022 SHALL, on each sample edge, shift synced sdi into the receive shift register LSB (MSB-first reception).
REQ-023 SHALL, on the sample edge where the counter wraps 7->0, copy the completed byte to rx_data_o and pulse rx_valid_o in the same cycle.
REQ-024 SHALL hold rx_data_o until the next complete byte; no backpressure: a new byte overwrites the old one.
REQ-025 SHALL define a load event as either: the IDLE->ACTIVE transition when CPHA=0; or any shift edge in ACTIVE with bit counter == 0, except the first shift edge after entry when CPHA=0.
REQ-026 SHALL, on a load event, load the tx shift register with tx_data_i and pulse tx_ready_o if tx_valid_i is high; otherwise it SHALL load 8'hFF and pulse tx_underrun_o.
REQ-027 SHALL shift the tx shift register left by one, filling with 1, on each shift edge in ACTIVE that is not a load event.
REQ-028 SHALL drive sdo_o = tx shift register MSB in ACTIVE and 1 in IDLE; sdo_en_o SHALL be 1 exactly in ACTIVE.
REQ-029 SHALL, on deassertion of synced cs_ni mid-byte, abort the byte: discard partial rx bits, produce no rx_valid_o, clear the counter and return to IDLE.
REQ-030 SHALL give deassertion of synced cs_ni priority over any SCK edge detected in the same cycle; that edge is ignored.
REQ-031 SHALL support back-to-back bytes within one cs_ni assertion with no gap cycles required.

Reset
REQ-032 SHALL, when rst_ni is low at a clk_i edge, enter IDLE, clear the counter and all shift registers, and set synchronizer flops to sck=CPOL, cs=1, sdi=1.
REQ-033 SHALL, during and after reset, drive sdo_o=1, sdo_en_o=0, tx_ready_o=0, tx_underrun_o=0, rx_data_o=8'h00 and rx_valid_o=0.
REQ-034 SHALL produce no spurious edge, load or rx_valid_o in the first cycles after reset release.

Verification
REQ-035 SHALL cover mode 0 with tx_valid_i=1 and tx_data_i=8'hA5 and host sending 8'h3C -> sdo bits 1,0,1,0,0,1,0,1; rx_data_o=8'h3C; exactly one rx_valid_o and one tx_ready_o.
REQ-036 SHALL cover mode 3 (CPOL=1, CPHA=1) with two back-to-back bytes 8'h81, 8'h7E in each direction -> both received in order, two rx_valid_o pulses, two tx_ready_o pulses.
REQ-037 SHALL cover tx_valid_i=0 at load -> sdo all ones for that byte and one tx_underrun_o pulse.
REQ-038 SHALL cover cs_ni deasserted after 5 bits -> no rx_valid_o, rx_data_o unchanged, sdo_en_o=0; the next full byte 8'h55 is received correctly.
REQ-039 SHALL cover rst_ni low mid-byte -> all outputs at reset values; the next transfer 8'hC3 is received correctly.
